pwm_generator_multi: RTL and testbench
======================================

Name: pwm_generator_multi

Overview:
- N-channel PWM generator on the CPU custom-instruction (CI) interface; successor to the 2-channel fixed-period generator.
- Adds a programmable period, double-buffered duty/period updates applied only at the period wrap (glitch-free), per-channel polarity, registered outputs and CI readback.
- Drives servo/motor PWM pins directly from the CPU custom-instruction slot.

Parameters:
- customId, 8'h00, CI number this block answers to.
- NUM_CHANNELS, 4, number of PWM outputs (1..16).
- COUNTER_WIDTH, 20, width of the period counter and of the duty/period registers (8..32).
- DEFAULT_PERIOD, 20'hFFFFF, period register value after reset (must fit COUNTER_WIDTH).
- RAMP_STEP, 256, duty step per period; used only with PWM_RAMP_EN.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  CI start strobe.
- ciN  input  8  CI number.
- valueA  input  32  command: [3:0] opcode, [11:8] channel index.
- valueB  input  32  write data.
- done  output  1  CI complete.
- result  output  32  CI read data.
- pwmPins  output  NUM_CHANNELS  PWM outputs.

Behaviour:
- Reset and CI handshake:
  - Single clock and asynchronous active-low reset, as decided.
  - sel = start && (ciN == customId). done = sel, combinational, so every command completes in 1 cycle.
  - result is 0 whenever done = 0.
- Opcodes (valueA[3:0]); writes take effect at the clock edge where sel = 1:
  - 0 STATUS: result = {counter wrap count[15:0], pending-update mask[15:0]}.
  - 1 WR_EN: enable mask <= valueB[NUM_CHANNELS-1:0]; applies immediately.
  - 2 WR_DUTY: shadow duty[ch] <= valueB[COUNTER_WIDTH-1:0]; sets pending[ch].
  - 3 WR_PERIOD: shadow period <= valueB[COUNTER_WIDTH-1:0].
  - 4 RD_DUTY: result = zero-extended active duty[ch].
  - 5 RD_PERIOD: result = zero-extended active period.
  - 6 WR_POL: polarity mask <= valueB[NUM_CHANNELS-1:0]; applies immediately.
  - 7 RD_CNT: result = zero-extended counter.
  - 8..15: no state change, result = 0.
- Channel index >= NUM_CHANNELS: writes ignored, reads return 0.
- Counter:
  - Counts 0..active_period, then wraps to 0.
  - Wrap cycle: counter == active_period.
  - active_period = 0 gives a wrap every cycle.
  - Wrap count is 16 bits, increments on every wrap and wraps modulo 2^16.
- Shadow transfer at wrap:
  - active_period <= shadow period.
  - active duty[ch] <= shadow duty[ch] for all channels.
  - pending mask cleared.
- Write in the same cycle as a wrap: the wrap transfers the pre-write shadow value. The new value is applied at the following wrap, and the pending bit stays set.
- Compare:
  - raw[ch] = en[ch] && (counter < active duty[ch]).
  - duty 0 gives a constant 0%. duty > active_period gives a constant 100%.
- Output: pwmPins[ch] <= raw[ch] ^ pol[ch], registered, so there is 1 cycle of latency from the counter.
  - A disabled channel outputs pol[ch].
- Reset values:
  - counter = 0; wrap count = 0; en = 0; pol = 0; pending = 0; pwmPins = 0.
  - all duties (shadow and active) = 0.
  - shadow and active period = DEFAULT_PERIOD.
- Reset asserted mid-period: all state clears immediately (asynchronously). After release, counting restarts from 0.

Optional Feature:
- Macro: PWM_RAMP_EN.
- Defined: at each wrap, active duty[ch] moves toward shadow duty[ch] by min(RAMP_STEP, |difference|) instead of jumping. pending[ch] clears only when active duty equals shadow duty.
- Undefined: the whole shadow duty is transferred at the wrap; the RAMP_STEP parameter is ignored.

Decomposition:
- Package pwm_pkg holds:
  - opcode constants OP_STATUS..OP_RD_CNT.
  - command field positions (opcode [3:0], channel [11:8]).
  - the wrap-count width (16).
- Sub-module pwm_channel, one per channel via generate, holds:
  - shadow and active duty registers and the pending bit.
  - the compare, polarity XOR and output register.
  - the ramp logic under PWM_RAMP_EN.
- The top level holds the counter, period registers, CI decode and result mux.

Test Plan:
- Reset defaults: hold reset low, then release. Expect pwmPins = 0 and RD_PERIOD = DEFAULT_PERIOD. RD_CNT increments by 1 per cycle.
- Basic duty: WR_PERIOD 9; wait for a wrap; WR_DUTY ch0 = 3; WR_EN = 1. Expect pwmPins[0] high for 3 of every 10 cycles, and the first high cycle only after the next wrap.
- Write on the wrap cycle: issue WR_DUTY ch1 = 5 exactly on the wrap. Expect RD_DUTY ch1 to keep its old value for one more period, and the pending bit set until the following wrap.
- Boundary values and polarity, with period 9:
  - duty 0 gives a constant 0.
  - duty 15 gives a constant 1.
  - with pol[2] = 1 and en[2] = 0, pwmPins[2] is a constant 1.
- Bad command and foreign CI:
  - channel index 15 with NUM_CHANNELS = 4: write ignored, result 0.
  - ciN != customId: done = 0, result = 0, no state change.
- Ramp (PWM_RAMP_EN, RAMP_STEP = 4): duty 0 to 10 gives active duty 4, 8, 10 over three wraps; pending clears at 10. Asserting reset in mid-period forces pwmPins = 0 immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: CI opcodes,
// command-word field positions and the wrap-count width.
// Optional feature macro used by this design: PWM_RAMP_EN.
package pwm_pkg;

  typedef enum logic [3:0] {
    OP_STATUS    = 4'd0,
    OP_WR_EN     = 4'd1,
    OP_WR_DUTY   = 4'd2,
    OP_WR_PERIOD = 4'd3,
    OP_RD_DUTY   = 4'd4,
    OP_RD_PERIOD = 4'd5,
    OP_WR_POL    = 4'd6,
    OP_RD_CNT    = 4'd7
  } pwm_op_e;

  // Command word layout in valueA
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int CH_LSB  = 8;
  localparam int CH_MSB  = 11;

  // Width of the period wrap counter reported by STATUS
  localparam int WRAP_CNT_W = 16;

endpackage

// File: rtl/pwm_generator_multi_channel.sv
// One PWM channel: shadow/active duty pair, pending flag, compare against
// the shared period counter, polarity and registered output.
// With PWM_RAMP_EN defined the active duty slews toward the shadow duty by
// at most RAMP_STEP per wrap; otherwise it jumps at the wrap.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 20,
  parameter int RAMP_STEP     = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wrap_i,
  input  logic                     wr_duty_i,
  input  logic [COUNTER_WIDTH-1:0] wdata_i,
  input  logic [COUNTER_WIDTH-1:0] counter_i,
  input  logic                     en_i,
  input  logic                     pol_i,
  output logic [COUNTER_WIDTH-1:0] duty_o,
  output logic                     pending_o,
  output logic                     pwm_o
);

  localparam int CW = COUNTER_WIDTH;

  logic [CW-1:0] shadow_q;
  logic [CW-1:0] active_q;
  logic [CW-1:0] active_d;
  logic          pending_q;
  logic          pending_d;
  logic          pwm_q;
  logic          raw;

`ifdef PWM_RAMP_EN
  localparam logic [CW:0] STEP = (CW + 1)'(RAMP_STEP);
  logic [CW-1:0] diff;

  // Next active duty: one bounded step toward the shadow value
  always_comb begin
    active_d = active_q;
    diff     = '0;
    if (shadow_q > active_q) begin
      diff     = shadow_q - active_q;
      active_d = ({1'b0, diff} > STEP) ? active_q + STEP[CW-1:0] : shadow_q;
    end else if (shadow_q < active_q) begin
      diff     = active_q - shadow_q;
      active_d = ({1'b0, diff} > STEP) ? active_q - STEP[CW-1:0] : shadow_q;
    end
  end

  // Pending stays up until the ramp has actually reached the shadow value
  always_comb begin
    pending_d = pending_q;
    if (wr_duty_i) begin
      pending_d = 1'b1;
    end else if (wrap_i && (active_d == shadow_q)) begin
      pending_d = 1'b0;
    end
  end
`else
  // Next active duty: the whole shadow value is taken at the wrap
  always_comb begin
    active_d = shadow_q;
  end

  // A write landing on the wrap cycle keeps pending set for the next wrap
  always_comb begin
    pending_d = pending_q;
    if (wr_duty_i) begin
      pending_d = 1'b1;
    end else if (wrap_i) begin
      pending_d = 1'b0;
    end
  end
`endif

  // Compare: duty 0 never fires, duty above the period always fires
  always_comb begin
    raw = en_i && (counter_i < active_q);
  end

  // Duty registers, pending flag and polarity-adjusted output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      if (wr_duty_i) begin
        shadow_q <= wdata_i;
      end
      if (wrap_i) begin
        active_q <= active_d;
      end
      pending_q <= pending_d;
      pwm_q     <= raw ^ pol_i;
    end
  end

  assign duty_o    = active_q;
  assign pending_o = pending_q;
  assign pwm_o     = pwm_q;

endmodule

// File: rtl/pwm_generator_multi.sv
// N-channel PWM generator on the CPU custom-instruction interface.
// Holds the shared period counter, double-buffered period, enable and
// polarity masks, command decode and readback mux. Duty handling lives in
// pwm_channel. Optional duty ramping is selected with PWM_RAMP_EN.
module pwm_generator_multi
  import pwm_pkg::*;
#(
  parameter logic [7:0]  customId       = 8'h00,
  parameter int          NUM_CHANNELS   = 4,
  parameter int          COUNTER_WIDTH  = 20,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h000F_FFFF,
  parameter int          RAMP_STEP      = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              ciN,
  input  logic [31:0]             valueA,
  input  logic [31:0]             valueB,
  output logic                    done,
  output logic [31:0]             result,
  output logic [NUM_CHANNELS-1:0] pwmPins
);

  localparam int            CW      = COUNTER_WIDTH;
  localparam logic [CW-1:0] DEF_PER = DEFAULT_PERIOD[CW-1:0];

  logic                  sel;
  logic [3:0]            opcode;
  logic [3:0]            ch_idx;
  logic                  wr_en;
  logic                  wr_pol;
  logic                  wr_duty;
  logic                  wr_period;
  logic                  wrap;

  logic [CW-1:0]         counter_q;
  logic [CW-1:0]         counter_d;
  logic [CW-1:0]         period_shadow_q;
  logic [CW-1:0]         period_active_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;
  logic [NUM_CHANNELS-1:0] en_q;
  logic [NUM_CHANNELS-1:0] pol_q;

  logic [CW-1:0]           duty_active [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending;
  logic [15:0]             pending_mask;
  logic [CW-1:0]           duty_sel;
  logic                    unused_bits;

  assign sel       = start && (ciN == customId);
  assign done      = sel;
  assign opcode    = valueA[OPC_MSB:OPC_LSB];
  assign ch_idx    = valueA[CH_MSB:CH_LSB];
  assign wr_en     = sel && (opcode == OP_WR_EN);
  assign wr_pol    = sel && (opcode == OP_WR_POL);
  assign wr_duty   = sel && (opcode == OP_WR_DUTY);
  assign wr_period = sel && (opcode == OP_WR_PERIOD);
  assign wrap      = (counter_q == period_active_q);

  assign pending_mask = 16'(pending);
  assign unused_bits  = ^{valueA[31:12], valueA[7:4], valueB};

  // Counter next state: count up to the active period, then restart at 0
  always_comb begin
    counter_d = wrap ? '0 : counter_q + 1'b1;
  end

  // Counter, period double buffer, wrap count and the immediate masks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_q       <= '0;
      period_shadow_q <= DEF_PER;
      period_active_q <= DEF_PER;
      wrap_cnt_q      <= '0;
      en_q            <= '0;
      pol_q           <= '0;
    end else begin
      counter_q <= counter_d;
      if (wrap) begin
        period_active_q <= period_shadow_q;
        wrap_cnt_q      <= wrap_cnt_q + 1'b1;
      end
      if (wr_period) begin
        period_shadow_q <= valueB[CW-1:0];
      end
      if (wr_en) begin
        en_q <= valueB[NUM_CHANNELS-1:0];
      end
      if (wr_pol) begin
        pol_q <= valueB[NUM_CHANNELS-1:0];
      end
    end
  end

  // One channel per output; out-of-range channel indices match no instance
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    pwm_channel #(
      .COUNTER_WIDTH(CW),
      .RAMP_STEP    (RAMP_STEP)
    ) u_ch (
      .clk_i    (clock),
      .rst_ni   (reset),
      .wrap_i   (wrap),
      .wr_duty_i(wr_duty && (ch_idx == 4'(gi))),
      .wdata_i  (valueB[CW-1:0]),
      .counter_i(counter_q),
      .en_i     (en_q[gi]),
      .pol_i    (pol_q[gi]),
      .duty_o   (duty_active[gi]),
      .pending_o(pending[gi]),
      .pwm_o    (pwmPins[gi])
    );
  end

  // Readback mux; result is held at 0 whenever the command is not ours
  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_idx == 4'(i)) begin
        duty_sel = duty_active[i];
      end
    end
    result = '0;
    if (sel) begin
      case (opcode)
        OP_STATUS:    result = {wrap_cnt_q, pending_mask};
        OP_RD_DUTY:   result = 32'(duty_sel);
        OP_RD_PERIOD: result = 32'(period_active_q);
        OP_RD_CNT:    result = 32'(counter_q);
        default:      result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_generator_multi.sv
// Directed bench for pwm_generator_multi. Build with PWM_RAMP_EN defined to
// exercise the ramping duty path instead of the basic duty/boundary steps.
module tb_pwm_generator_multi;
  import pwm_pkg::*;

  localparam logic [7:0]  ID      = 8'h3C;
  localparam logic [7:0]  OTHER   = 8'h00;
  localparam logic [31:0] DEF_PER = 32'd63;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;
  logic [3:0]  pwmPins;

  logic [31:0] r;
  logic        d;
  logic [3:0]  p;
  int          checks = 0;
  int          failures = 0;
  int          highs;
  int          cnt_exp;
  logic [3:0]  pin_exp;

  pwm_generator_multi #(
    .customId      (ID),
    .NUM_CHANNELS  (4),
    .COUNTER_WIDTH (20),
    .DEFAULT_PERIOD(DEF_PER),
    .RAMP_STEP     (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result),
    .pwmPins(pwmPins)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One CI transaction: drive on the falling edge, sample 1 ns later
  task automatic ci(input logic [7:0] id, input logic [3:0] op, input logic [3:0] ch,
                    input logic [31:0] b);
    @(negedge clock);
    start  = 1'b1;
    ciN    = id;
    valueA = {20'd0, ch, 4'd0, op};
    valueB = b;
    #1;
    r = result;
    d = done;
    p = pwmPins;
    $display("txn ci=%02h op=%0d ch=%0d b=%08h -> done=%0b result=%08h pins=%04b",
             id, op, ch, b, d, r, p);
    @(posedge clock);
    #1;
    start  = 1'b0;
    ciN    = 8'h00;
    valueA = '0;
    valueB = '0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [3:0] ch, input logic [31:0] b);
    ci(ID, op, ch, b);
  endtask

  // Poll the counter until it reads target; returns one cycle later
  task automatic wait_cnt(input logic [31:0] target);
    int n = 0;
    do begin
      cmd(OP_RD_CNT, 4'd0, 32'd0);
      n++;
    end while (r !== target && n < 200);
    chk("wait_cnt", r, target);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    ciN    = 8'h00;
    valueA = '0;
    valueB = '0;

    // Reset defaults
    repeat (3) @(negedge clock);
    chk("rst_pins", {28'd0, pwmPins}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b1;
    cmd(OP_RD_PERIOD, 4'd0, 32'd0);
    chk("rst_period", r, DEF_PER);
    chk("rst_done_own", {31'd0, d}, 32'd1);
    cmd(OP_RD_CNT, 4'd0, 32'd0);
    chk("cnt_a", r, 32'd2);
    cmd(OP_RD_CNT, 4'd0, 32'd0);
    chk("cnt_b", r, 32'd3);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("rst_status", r, 32'd0);

    // Program period 9; it becomes active at the default-period wrap
    cmd(OP_WR_PERIOD, 4'd0, 32'd9);
    wait_cnt(DEF_PER);
    cmd(OP_RD_PERIOD, 4'd0, 32'd0);
    chk("period9", r, 32'd9);

`ifdef PWM_RAMP_EN
    // Ramp 0 -> 10 in steps of 4
    cmd(OP_WR_DUTY, 4'd0, 32'd10);
    wait_cnt(32'd9);
    cmd(OP_RD_DUTY, 4'd0, 32'd0);
    chk("ramp_4", r, 32'd4);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("ramp_st4", r, 32'h0002_0001);
    wait_cnt(32'd9);
    cmd(OP_RD_DUTY, 4'd0, 32'd0);
    chk("ramp_8", r, 32'd8);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("ramp_st8", r, 32'h0003_0001);
    wait_cnt(32'd9);
    cmd(OP_RD_DUTY, 4'd0, 32'd0);
    chk("ramp_10", r, 32'd10);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("ramp_st10", r, 32'h0004_0000);
    cmd(OP_WR_EN, 4'd0, 32'd1);
    cmd(OP_RD_CNT, 4'd0, 32'd0);
    cmd(OP_RD_CNT, 4'd0, 32'd0);
    chk("ramp_pin_full", {28'd0, p}, 32'd1);
`else
    // Basic duty: 3 of 10 cycles, first high only after the next wrap
    cmd(OP_RD_CNT, 4'd0, 32'd0);
    chk("cnt_after_wrap", r, 32'd1);
    cmd(OP_WR_DUTY, 4'd0, 32'd3);
    cmd(OP_WR_EN, 4'd0, 32'd1);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("status_pend0", r, 32'h0001_0001);
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      cmd(OP_RD_CNT, 4'd0, 32'd0);
      cnt_exp = (5 + i) % 10;
      pin_exp = (i >= 5 && cnt_exp >= 1 && cnt_exp <= 3) ? 4'b0001 : 4'b0000;
      chk("basic_cnt", r, 32'(cnt_exp));
      chk("basic_pin", {28'd0, p}, {28'd0, pin_exp});
      highs += int'(p[0]);
    end
    chk("basic_highs", 32'(highs), 32'd3);

    // Duty write landing exactly on the wrap cycle
    wait_cnt(32'd8);
    cmd(OP_WR_DUTY, 4'd1, 32'd5);
    cmd(OP_RD_DUTY, 4'd1, 32'd0);
    chk("wrapwr_old", r, 32'd0);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("wrapwr_pend", r, 32'h0004_0002);
    cmd(OP_RD_DUTY, 4'd0, 32'd0);
    chk("duty0_3", r, 32'd3);
    wait_cnt(32'd9);
    cmd(OP_RD_DUTY, 4'd1, 32'd0);
    chk("wrapwr_new", r, 32'd5);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("wrapwr_clr", r, 32'h0005_0000);

    // Boundaries: ch0 duty 0, ch1 duty 15, ch2 disabled with pol 1
    cmd(OP_WR_DUTY, 4'd0, 32'd0);
    cmd(OP_WR_DUTY, 4'd1, 32'd15);
    cmd(OP_WR_POL, 4'd0, 32'h4);
    cmd(OP_WR_EN, 4'd0, 32'h3);
    wait_cnt(32'd0);
    for (int i = 0; i < 10; i++) begin
      cmd(OP_RD_CNT, 4'd0, 32'd0);
      chk("bound_cnt", r, 32'((1 + i) % 10));
      chk("bound_pins", {28'd0, p}, 32'h6);
    end

    // Bad channel index and foreign CI number
    cmd(OP_WR_DUTY, 4'd15, 32'd7);
    chk("bad_wr_done", {31'd0, d}, 32'd1);
    chk("bad_wr_result", r, 32'd0);
    cmd(OP_RD_DUTY, 4'd15, 32'd0);
    chk("bad_rd", r, 32'd0);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("bad_status", r, 32'h0007_0000);
    ci(OTHER, OP_WR_EN, 4'd0, 32'd0);
    chk("foreign_done", {31'd0, d}, 32'd0);
    chk("foreign_result", r, 32'd0);
    ci(OTHER, OP_RD_CNT, 4'd0, 32'd0);
    chk("foreign_rd", r, 32'd0);
    cmd(4'd9, 4'd0, 32'hFFFF_FFFF);
    chk("op9_result", r, 32'd0);
    chk("op9_done", {31'd0, d}, 32'd1);
    chk("foreign_noeffect", {28'd0, p}, 32'h6);
    cmd(OP_RD_DUTY, 4'd3, 32'd0);
    chk("no_alias", r, 32'd0);
`endif

    // Reset mid-period clears outputs without waiting for a clock edge
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_pins", {28'd0, pwmPins}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cmd(OP_RD_CNT, 4'd0, 32'd0);
    chk("midrst_cnt", r, 32'd1);
    cmd(OP_RD_PERIOD, 4'd0, 32'd0);
    chk("midrst_period", r, DEF_PER);
    cmd(OP_STATUS, 4'd0, 32'd0);
    chk("midrst_status", r, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
